// File: rtl/parity_pkg.sv
// Shared types and constants for the registered parity generator.
package parity_pkg;

   typedef enum logic {
      EVEN_PAR = 1'b0,
      ODD_PAR  = 1'b1
   } parity_t;

   localparam logic ParBitRst = 1'b0;

endpackage : parity_pkg

// File: rtl/xor_reduce.sv
// Balanced XOR reduction tree: red_o is the XOR of all bits of data_i.
module xor_reduce #(
   parameter int unsigned Width = 8
) (
   input  logic [Width-1:0] data_i,
   output logic             red_o
);

   localparam int unsigned Levels = (Width > 1) ? $clog2(Width) : 0;
   localparam int unsigned Leaves = 1 << Levels;

   // Heap-ordered tree: node 1 is the root, leaves sit at Leaves..2*Leaves-1.
   logic [2*Leaves-1:1] node;

   for (genvar j = 0; j < Leaves; j++) begin : g_leaf
      if (j < Width) begin : g_data
         assign node[Leaves+j] = data_i[j];
      end else begin : g_pad
         assign node[Leaves+j] = 1'b0;
      end
   end

   for (genvar i = 1; i < Leaves; i++) begin : g_node
      assign node[i] = node[2*i] ^ node[2*i+1];
   end

   assign red_o = node[1];

endmodule : xor_reduce

// File: rtl/parity_gen.sv
// Registered even/odd parity bit over a data word, one cycle of latency.
module parity_gen
   import parity_pkg::*;
#(
   parameter int unsigned data_width = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [data_width-1:0] p_data,
   input  logic                  par_typ,
   output logic                  par_bit
);

   logic    data_red;
   parity_t typ;
   logic    par_bit_d, par_bit_q;

   assign typ = parity_t'(par_typ);

   xor_reduce #(
      .Width (data_width)
   ) u_xor_reduce (
      .data_i (p_data),
      .red_o  (data_red)
   );

   always_comb begin
      par_bit_d = data_red ^ (typ == ODD_PAR);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         par_bit_q <= ParBitRst;
      end else begin
         par_bit_q <= par_bit_d;
      end
   end

   assign par_bit = par_bit_q;

endmodule : parity_gen

// File: tb/tb_parity_gen.sv
// Self-checking bench for parity_gen at widths 1, 8 and 13.
module tb_parity_gen;

   logic        clk;
   logic        rst;
   logic [0:0]  d1;
   logic [7:0]  d8;
   logic [12:0] d13;
   logic        typ;
   logic        pb1, pb8, pb13;

   int n_checks = 0;
   int n_fails  = 0;

   parity_gen #(.data_width(1)) u_dut1 (
      .clk(clk), .rst(rst), .p_data(d1), .par_typ(typ), .par_bit(pb1)
   );
   parity_gen #(.data_width(8)) u_dut8 (
      .clk(clk), .rst(rst), .p_data(d8), .par_typ(typ), .par_bit(pb8)
   );
   parity_gen #(.data_width(13)) u_dut13 (
      .clk(clk), .rst(rst), .p_data(d13), .par_typ(typ), .par_bit(pb13)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: parity bit from the count of ones and the requested type.
   function automatic logic ref_par(input int ones, input logic t);
      logic odd_ones;
      odd_ones = (ones % 2) == 1;
      return t ? !odd_ones : odd_ones;
   endfunction

   task automatic check(input string tag, input logic obs, input logic exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fails++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   logic e1, e8, e13;

   initial begin
      rst = 1'b0; typ = 1'b0; d1 = 1'b1; d8 = 8'b10101011; d13 = '1;
      tick();
      check("reset_w1", pb1, 1'b0);
      check("reset_w8", pb8, 1'b0);
      check("reset_w13", pb13, 1'b0);

      // Deassert: first edge loads parity of the present inputs.
      rst = 1'b1; d8 = 8'b10101001; typ = 1'b0;
      tick();
      check("even_even_ones", pb8, 1'b0);

      d8 = 8'b10101101; typ = 1'b0;
      tick();
      check("even_odd_ones", pb8, 1'b1);

      d8 = 8'b10101101; typ = 1'b1;
      tick();
      check("odd_odd_ones", pb8, 1'b0);

      d8 = 8'b10101001; typ = 1'b1;
      tick();
      check("odd_even_ones", pb8, 1'b1);

      // Reset asserted between edges must not act until the next edge.
      rst = 1'b0;
      #2;
      check("reset_is_sync", pb8, 1'b1);
      tick();
      check("reset_mid_stream", pb8, 1'b0);

      rst = 1'b1; d8 = 8'h00; typ = 1'b1;
      tick();
      check("zero_odd", pb8, 1'b1);

      // Randomised sweep; first two words are all-zeros and all-ones.
      for (int i = 0; i < 300; i++) begin
         if (i == 0 || i == 2) begin
            d1 = '0; d8 = '0; d13 = '0;
         end else if (i == 1 || i == 3) begin
            d1 = '1; d8 = '1; d13 = '1;
         end else begin
            d1  = 1'($urandom);
            d8  = 8'($urandom);
            d13 = 13'($urandom);
         end
         typ = (i < 4) ? i[1] : 1'($urandom_range(0, 1));
         e1  = ref_par($countones(d1), typ);
         e8  = ref_par($countones(d8), typ);
         e13 = ref_par($countones(d13), typ);
         tick();
         check("sweep_w1", pb1, e1);
         check("sweep_w8", pb8, e8);
         check("sweep_w13", pb13, e13);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule : tb_parity_gen
